// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus geometry and the initiator FSM encoding.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 16;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_GRANULE    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2,
    RESPOND  = 2'd3
  } wb_master_state_t;

endpackage

// File: rtl/wb_master_if.sv
// Command port plus Wishbone pipelined bus of wb_master; signal suffixes are from the master's side.
interface wb_master_if
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int GRANULE    = WB_GRANULE
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  // Command handshake: a command transfers on a rising edge where cmd_valid_i && cmd_ready_o;
  // the requester holds fields stable while valid is high. Responses are a one-cycle
  // rsp_valid_o pulse with no backpressure.
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic [SEL_WIDTH-1:0]  cmd_sel_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [SEL_WIDTH-1:0]  sel_o;
  logic                  we_o;
  logic                  stb_o;
  logic                  cyc_o;
  logic                  ack_i;
  logic                  err_i;
  logic                  stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o,
    input  dat_i, ack_i, err_i, stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o,
    output dat_i, ack_i, err_i, stall_i
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Per-transaction cycle counter for the bus-phase watchdog; limit_o is high in the LIMIT-th counted cycle.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Firing at LIMIT-1 lets the owner leave on the edge where the count reaches LIMIT.
  assign limit_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master.sv
// Wishbone pipelined initiator, one transaction outstanding. Define WB_MASTER_TIMEOUT_EN to
// abort a bus phase with an error after TIMEOUT_CYCLES cycles.
module wb_master
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int GRANULE        = WB_GRANULE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_master_if.master bus,
  output logic [1:0]  state_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  localparam logic [1:0] ST_IDLE     = 2'(IDLE);
  localparam logic [1:0] ST_REQUEST  = 2'(REQUEST);
  localparam logic [1:0] ST_WAIT_ACK = 2'(WAIT_ACK);
  localparam logic [1:0] ST_RESPOND  = 2'(RESPOND);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64) ||
      (DATA_WIDTH % GRANULE) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_master: unsupported DATA_WIDTH/GRANULE/TIMEOUT_CYCLES combination");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;

  logic in_bus_phase;
  logic rsp_seen;
  logic timeout;

  assign in_bus_phase = (state_q == ST_REQUEST) || (state_q == ST_WAIT_ACK);

  // A slave reply counts in REQUEST only once the strobe has been taken (stall low).
  assign rsp_seen = ((state_q == ST_REQUEST) && !bus.stall_i && (bus.ack_i || bus.err_i)) ||
                    ((state_q == ST_WAIT_ACK) && (bus.ack_i || bus.err_i));

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   ((state_q == ST_IDLE) && bus.cmd_valid_i),
    .en_i    (in_bus_phase),
    .limit_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
          we_d    = bus.cmd_we_i;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST, ST_WAIT_ACK: begin
        if (rsp_seen) begin
          state_d   = ST_RESPOND;
          rsp_err_d = bus.err_i;
          rsp_dat_d = (!bus.err_i && !we_q) ? bus.dat_i : '0;
        end else if (timeout) begin
          state_d   = ST_RESPOND;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
        end else if ((state_q == ST_REQUEST) && !bus.stall_i) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == ST_IDLE);
  assign bus.cyc_o       = in_bus_phase;
  assign bus.stb_o       = (state_q == ST_REQUEST);
  assign bus.adr_o       = adr_q;
  assign bus.dat_o       = dat_q;
  assign bus.sel_o       = sel_q;
  assign bus.we_o        = we_q;
  assign bus.rsp_valid_o = (state_q == ST_RESPOND);
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: a vector table of transactions against a byte-lane memory slave,
// plus hand-written reset, idle-ack and stall/timeout sequences.
`timescale 1ns/1ps
module tb_wb_master;
  import wb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int GR = 8;
  localparam int TO = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall_n;  // cycles stall_i is held at the start of REQUEST
    int          ack_dly;  // cycles between the accepted strobe and the reply
    int          kind;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;  // cycles stb_o observed high
    int          exp_lat;  // cycle index (handshake cycle = 0) in which rsp_valid_o is high
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  logic [31:0]   mem [0:255];
  logic [DW-1:0] exp_q [$];
  vec_t          vecs [8];
  vec_t          v_after_rst;
  int            tests = 0;
  int            fails = 0;

  wb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(GR)) bus ();

  wb_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .GRANULE        (GR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    bus.stall_i = 1'b0;
    bus.ack_i   = 1'b0;
    bus.err_i   = 1'b0;
    bus.dat_i   = 32'h0;
  endtask

  // Presents a command at a negedge, checks it is accepted, and drops valid just after the edge.
  task automatic issue_cmd(input string tag, input logic we, input logic [15:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    check({tag, " cmd_ready"}, bus.cmd_ready_o, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = ~we;
    bus.cmd_adr_i   = 16'hFFFF;
    bus.cmd_dat_i   = 32'h0BAD_F00D;
    bus.cmd_sel_i   = 4'h0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          rc;
    int          stb_cnt;
    int          lat;
    bit          got;
    logic [31:0] m;
    rc      = v.stall_n + 1 + v.ack_dly;
    stb_cnt = 0;
    lat     = -1;
    got     = 1'b0;
    exp_q.push_back(v.exp_dat);
    issue_cmd(tag, v.we, v.adr, v.dat, v.sel);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      bus.stall_i = (c <= v.stall_n);
      bus.ack_i   = (c == rc) && (v.kind != K_ERR);
      bus.err_i   = (c == rc) && (v.kind != K_ACK);
      bus.dat_i   = (c == rc && !v.we) ? mem[v.adr[7:0]] : (32'hA5A5_0000 | 32'(c));
      if (bus.stb_o) begin
        stb_cnt++;
        check({tag, " bus fields"}, {bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o},
              {v.we, v.sel, v.adr, v.dat});
      end
      check({tag, " cmd_ready busy"}, bus.cmd_ready_o, 0);
      if (c == rc && v.we && v.kind == K_ACK) begin
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (bus.sel_o[b]) m[b*8 +: 8] = 8'hFF;
        mem[v.adr[7:0]] = (mem[v.adr[7:0]] & ~m) | (bus.dat_o & m);
      end
      if (bus.rsp_valid_o) begin
        got = 1'b1;
        lat = c;
      end
    end
    slave_idle();
    check({tag, " rsp seen"}, got, 1);
    check({tag, " rsp latency"}, lat, v.exp_lat);
    check({tag, " stb cycles"}, stb_cnt, v.exp_stb);
    check({tag, " rsp_err"}, bus.rsp_err_o, v.exp_err);
    check({tag, " rsp_dat"}, bus.rsp_dat_o, exp_q.pop_front());
    @(negedge clk);
    check({tag, " rsp pulse width"}, bus.rsp_valid_o, 0);
    check({tag, " cmd_ready after"}, bus.cmd_ready_o, 1);
    check({tag, " cyc after"}, bus.cyc_o, 0);
    check({tag, " rsp_dat hold"}, bus.rsp_dat_o, v.exp_dat);
  endtask

  initial begin
    //             we    adr       dat           sel   stl dly kind    err   exp_dat       stb lat
    vecs[0] = '{1'b1, 16'h0003, 32'hDEADBEEF, 4'hF, 0, 1, K_ACK,  1'b0, 32'h00000000, 1, 3};
    vecs[1] = '{1'b0, 16'h0003, 32'h11110000, 4'hF, 0, 1, K_ACK,  1'b0, 32'hDEADBEEF, 1, 3};
    vecs[2] = '{1'b1, 16'h0010, 32'h12345678, 4'h3, 4, 1, K_ACK,  1'b0, 32'h00000000, 5, 7};
    vecs[3] = '{1'b0, 16'h0010, 32'h0,        4'hF, 0, 0, K_ACK,  1'b0, 32'h00005678, 1, 2};
    vecs[4] = '{1'b0, 16'h0020, 32'h0,        4'hF, 0, 2, K_ERR,  1'b1, 32'h00000000, 1, 4};
    vecs[5] = '{1'b1, 16'h0020, 32'hCAFEF00D, 4'hC, 1, 1, K_BOTH, 1'b1, 32'h00000000, 2, 4};
    vecs[6] = '{1'b0, 16'h0005, 32'h0,        4'h1, 2, 0, K_BOTH, 1'b1, 32'h00000000, 3, 4};
    vecs[7] = '{1'b0, 16'h0003, 32'h0,        4'hF, 2, 3, K_ACK,  1'b0, 32'hDEADBEEF, 3, 7};
    v_after_rst = '{1'b0, 16'h0003, 32'h0, 4'hF, 0, 1, K_ACK, 1'b0, 32'hDEADBEEF, 1, 3};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    slave_idle();

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", bus.cmd_ready_o, 1);
    check("reset cyc/stb/we", {bus.cyc_o, bus.stb_o, bus.we_o}, 3'b000);
    check("reset rsp_valid/err", {bus.rsp_valid_o, bus.rsp_err_o}, 2'b00);
    check("reset adr/sel", {bus.adr_o, bus.sel_o}, 20'h0);
    check("reset dat/rsp_dat", {bus.dat_o, bus.rsp_dat_o}, 64'h0);
    check("reset state", state, 2'(IDLE));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Replies while no cycle is open must be ignored
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.ack_i = 1'b1;
      bus.err_i = 1'b1;
      bus.dat_i = 32'h5555AAAA;
      check("idle ack ignored", {bus.cyc_o, bus.rsp_valid_o, bus.cmd_ready_o}, 3'b001);
    end
    @(negedge clk);
    slave_idle();
    check("idle ack rsp hold", {bus.rsp_err_o, bus.rsp_dat_o}, {1'b0, 32'hDEADBEEF});

    // Reset while waiting for the acknowledge
    issue_cmd("mid-reset", 1'b0, 16'h0003, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("mid-reset wait_ack", {bus.cyc_o, bus.stb_o}, 2'b10);
    rst = 1'b1;
    #1;
    check("mid-reset async drop", {bus.cyc_o, bus.stb_o, bus.rsp_valid_o}, 3'b000);
    check("mid-reset adr cleared", bus.adr_o, 16'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid-reset no rsp", bus.rsp_valid_o, 0);
    end
    rst = 1'b0;
    run_txn(v_after_rst, "post-reset read");

`ifdef WB_MASTER_TIMEOUT_EN
    // Silent slave: the edge that reaches TO counted cycles moves to RESPOND, so
    // rsp_valid_o is high in cycle TO+1 counting the handshake cycle as 0.
    begin
      int lat;
      lat = -1;
      issue_cmd("timeout", 1'b0, 16'h0040, 32'h0, 4'hF);
      for (int c = 1; c <= 30 && lat < 0; c++) begin
        @(negedge clk);
        if (bus.rsp_valid_o) lat = c;
      end
      check("timeout latency", lat, TO + 1);
      check("timeout rsp_err", bus.rsp_err_o, 1);
      check("timeout rsp_dat", bus.rsp_dat_o, 32'h0);
      check("timeout cyc dropped", {bus.cyc_o, bus.stb_o}, 2'b00);
      @(negedge clk);
      check("timeout cyc after", bus.cyc_o, 0);
    end
`else
    // Without the watchdog a silent slave keeps the cycle open indefinitely.
    begin
      int seen;
      seen = 0;
      issue_cmd("no-timeout", 1'b0, 16'h0003, 32'h0, 4'hF);
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (bus.rsp_valid_o) seen++;
      end
      check("no-timeout no rsp", seen, 0);
      check("no-timeout cyc held", {bus.cyc_o, bus.stb_o}, 2'b10);
      bus.ack_i = 1'b1;
      bus.dat_i = mem[8'h03];
      @(negedge clk);
      slave_idle();
      check("no-timeout late ack", {bus.rsp_valid_o, bus.rsp_err_o}, 2'b10);
      check("no-timeout rsp_dat", bus.rsp_dat_o, 32'hDEADBEEF);
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_master.md
Name: wb_master

Overview:
- Wishbone pipelined-mode initiator. It converts a simple valid/ready command port into single Wishbone classic-pipelined transactions.
- Drives the register-array slaves on the peripheral bus: one transaction outstanding at a time, with stall and error handling.
- Sits between the control/sequencer logic and the Wishbone interconnect.

Parameters:
- ADDR_WIDTH, 16, width of cmd_adr_i and adr_o.
- DATA_WIDTH, 32, data bus width; legal values 8/16/32/64.
- GRANULE, 8, select granularity in bits. SEL_WIDTH = DATA_WIDTH/GRANULE is a localparam.
- TIMEOUT_CYCLES, 255, cycles allowed per bus phase before abort; used only with the optional feature.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  target address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_sel_i  in  SEL_WIDTH  byte-lane select.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_dat_o  out  DATA_WIDTH  read data.
- rsp_err_o  out  1  transaction ended in error, valid with rsp_valid_o.
- adr_o  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- sel_o  out  SEL_WIDTH  Wishbone select.
- we_o  out  1  Wishbone write enable.
- stb_o  out  1  Wishbone strobe.
- cyc_o  out  1  Wishbone cycle.
- ack_i  in  1  slave acknowledge.
- err_i  in  1  slave error.
- stall_i  in  1  slave stall.

Behaviour:
- Reset (async, active-high): state=IDLE. cmd_ready_o=1; stb_o, cyc_o, we_o, rsp_valid_o, rsp_err_o = 0; adr_o, dat_o, sel_o, rsp_dat_o = 0. Asserting reset mid-transaction drops cyc_o/stb_o immediately, with no response.
- States are IDLE, REQUEST, WAIT_ACK and RESPOND.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch we/adr/dat/sel onto the bus outputs and go to REQUEST.
  - For reads, dat_o is still driven with the latched value (no zeroing).
- REQUEST:
  - cyc_o=1, stb_o=1, cmd_ready_o=0.
  - stall_i=1: hold all bus outputs, stay.
  - stall_i=0: request is accepted this edge. If ack_i or err_i is also high, go to RESPOND; otherwise go to WAIT_ACK.
- WAIT_ACK:
  - cyc_o=1, stb_o=0.
  - err_i goes to RESPOND with error; ack_i goes to RESPOND with success.
  - ack_i and err_i together: err wins.
- Read data: captured into rsp_dat_o on a successful read ack. Writes or errors load rsp_dat_o=0.
- RESPOND:
  - cyc_o=0, rsp_valid_o=1 for exactly one cycle, rsp_err_o set accordingly.
  - Next state is IDLE.
  - rsp_dat_o/rsp_err_o hold until the next response; rsp_valid_o returns to 0.
- Latency, zero-stall slave acking one cycle after stb: cmd accept edge -> stb high 1 cycle -> ack -> rsp_valid_o 3 cycles after accept.
- ack_i/err_i received while cyc_o=0 are ignored.
- The response port has no backpressure; the consumer must take the rsp_valid_o pulse.
- A new command is accepted only in IDLE (one outstanding transaction).

Optional Feature:
- Macro WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQUEST and counts every cycle in REQUEST/WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES, go to RESPOND with rsp_err_o=1; stb_o and cyc_o drop at that edge.
  - An ack/err arriving in the timeout cycle takes priority over the timeout.
- Not defined: no counter; the master waits indefinitely for stall release or ack/err.

Decomposition:
- Package wb_pkg:
  - wb_master_state_t enum (IDLE, REQUEST, WAIT_ACK, RESPOND).
  - Default ADDR_WIDTH/DATA_WIDTH/GRANULE constants, shared with the slave-side blocks.
- Optional sub-module wb_timeout_counter (clear, enable, limit-reached output), instantiated only under WB_MASTER_TIMEOUT_EN.
- Everything else stays flat.

Test Plan:
- Write, adr=0x0003, dat=0xDEADBEEF, sel=4'hF, zero-stall slave -> stb_o high 1 cycle with those values and we_o=1; rsp_valid_o pulse 3 cycles after accept; rsp_err_o=0, rsp_dat_o=0.
- Read adr=0x0003 after the write above -> rsp_dat_o=0xDEADBEEF, rsp_err_o=0; cmd_ready_o low from accept until the cycle after rsp_valid_o.
- stall_i held 4 cycles during REQUEST -> stb_o high 5 cycles with adr/dat/sel stable; exactly one response.
- err_i returned for adr=0x0020 -> rsp_err_o=1, rsp_dat_o=0; ack_i and err_i asserted together -> rsp_err_o=1.
- rst_i asserted while in WAIT_ACK -> cyc_o/stb_o drop asynchronously with no rsp_valid_o; a read issued after release completes normally.
- With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> rsp_valid_o with rsp_err_o=1 exactly 8 cycles after REQUEST entry; cyc_o low afterwards.
